// File: rtl/csa_pkg.sv
// Shared types and helpers for the pipelined carry-select adder/subtractor.
// The saturation helpers are only referenced when CSA_SAT_EN is defined.
package csa_pkg;

    // Conditional results of one 4-bit carry-select block
    typedef struct packed {
        logic [3:0] sum0;
        logic       c0;
        logic [3:0] sum1;
        logic       c1;
    } cond_res_t;

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic ovf_of(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/csa_blk_pre.sv
// One carry-select block: both conditional sums and carries, for carry-in 0 and 1.
module csa_blk_pre
    import csa_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] sum0,
    output logic           c0,
    output logic [BLK-1:0] sum1,
    output logic           c1
);

    always_comb begin
        {c0, sum0} = {1'b0, a} + {1'b0, b};
        {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Define CSA_SAT_EN to saturate the result to signed max/min on overflow.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    logic [WIDTH-1:0]           b_eff;
    logic                       cin_eff;
    logic [NBLK-1:0][BLK-1:0]   pre_sum0;
    logic [NBLK-1:0][BLK-1:0]   pre_sum1;
    logic [NBLK-1:0]            pre_c0;
    logic [NBLK-1:0]            pre_c1;

    logic                       s1_valid;
    logic [NBLK-1:0][BLK-1:0]   s1_sum0;
    logic [NBLK-1:0][BLK-1:0]   s1_sum1;
    logic [NBLK-1:0]            s1_c0;
    logic [NBLK-1:0]            s1_c1;
    logic                       s1_cin;
    logic                       s1_a_msb;
    logic                       s1_b_msb;

    logic                       adv2;
    logic                       accept;
    logic [NBLK:0]              carry;
    logic [NBLK-1:0][BLK-1:0]   sel_sum;
    logic [WIDTH-1:0]           sum_wrap;
    logic [WIDTH-1:0]           sum_nxt;
    logic                       ovf_nxt;

    assign b_eff   = b ^ {WIDTH{sub}};
    assign cin_eff = sub | cin;

    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_blk_pre #(.BLK(BLK)) u_pre (
            .a    (a[k*BLK +: BLK]),
            .b    (b_eff[k*BLK +: BLK]),
            .sum0 (pre_sum0[k]),
            .c0   (pre_c0[k]),
            .sum1 (pre_sum1[k]),
            .c1   (pre_c1[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_c0    <= '0;
            s1_c1    <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_sum0  <= pre_sum0;
            s1_sum1  <= pre_sum1;
            s1_c0    <= pre_c0;
            s1_c1    <= pre_c1;
            s1_cin   <= cin_eff;
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b_eff[WIDTH-1];
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Carry ripples only through the per-block select muxes, starting from the real carry-in
    always_comb begin
        carry    = '0;
        sel_sum  = '0;
        carry[0] = s1_cin;
        for (int k = 0; k < NBLK; k++) begin
            sel_sum[k]   = carry[k] ? s1_sum1[k] : s1_sum0[k];
            carry[k+1]   = carry[k] ? s1_c1[k]   : s1_c0[k];
        end
        sum_wrap = sel_sum;
        // Carry into the MSB is recovered from the MSB block's sum bit and its operand bits
        ovf_nxt  = ovf_of(s1_a_msb ^ s1_b_msb ^ sum_wrap[WIDTH-1], carry[NBLK]);
    end

`ifdef CSA_SAT_EN
    localparam logic [63:0] SAT_MAX_W = sat_max(WIDTH);
    localparam logic [63:0] SAT_MIN_W = sat_min(WIDTH);

    // On overflow a clear carry-out means both operands were positive
    always_comb begin
        sum_nxt = sum_wrap;
        if (ovf_nxt) begin
            sum_nxt = carry[NBLK] ? SAT_MIN_W[WIDTH-1:0] : SAT_MAX_W[WIDTH-1:0];
        end
    end
`else
    assign sum_nxt = sum_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= 1'b1;
            sum       <= sum_nxt;
            cout      <= carry[NBLK];
            ovf       <= ovf_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed and random checks for csa_pipe_adder (WIDTH=16, BLK=4).
// Expected results follow CSA_SAT_EN when it is defined for the build.
module tb_csa_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total_checks = 0;
    int passed_checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs[12];
    logic [17:0] exp_q[$];

    csa_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign-based reference: overflow when operand signs agree and the result sign differs
    function automatic logic [17:0] ref_calc(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rcin, input logic rsub);
        logic [15:0] be;
        logic [16:0] full;
        logic [15:0] s;
        logic        o;
        be   = rsub ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, be} + {16'b0, (rsub | rcin)};
        s    = full[15:0];
        o    = (ra[15] == be[15]) && (s[15] != ra[15]);
`ifdef CSA_SAT_EN
        if (o) s = ra[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, full[16], o};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin, input logic vsub, input logic vvalid);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = vvalid;
    endtask

    // One clock: sample at negedge, score pops, record accepts, return just after posedge
    task automatic run_cycle(output bit acc, output bit pop);
        logic [17:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (pop) begin
            checkOutput("queue_nonempty_on_pop", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("stream_result", {14'b0, sum, cout, ovf}, {14'b0, e});
            end
        end
        if (acc) exp_q.push_back(ref_calc(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          acc;
        bit          pop;
        int          idx;
        int          pops;
        int          cycles;
        logic [17:0] e;
        logic [15:0] bp_a[4];
        logic [15:0] bp_b[4];
        logic        bp_sub[4];

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 16'h5556, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 16'h1001, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vecs[11] = '{16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_outputs", {13'b0, out_valid, sum, cout, ovf}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: one beat each, result expected two edges after accept
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1);
            @(posedge clk);
            #1;
            applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
`ifdef CSA_SAT_EN
            e = {vecs[i].exp_sat, vecs[i].exp_cout, vecs[i].exp_ovf};
`else
            e = {vecs[i].exp_wrap, vecs[i].exp_cout, vecs[i].exp_ovf};
`endif
            checkOutput($sformatf("vec%0d", i), {13'b0, out_valid, sum, cout, ovf}, {13'b0, 1'b1, e});
        end
        @(posedge clk);
        #1;

        // Back-pressure: four beats with the consumer stalled
        bp_a   = '{16'h1111, 16'hF000, 16'h0003, 16'h7FFF};
        bp_b   = '{16'h2222, 16'h1000, 16'h0004, 16'h7FFF};
        bp_sub = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.delete();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(bp_a[idx], bp_b[idx], 1'b0, bp_sub[idx], 1'b1);
            run_cycle(acc, pop);
            if (acc) idx++;
            if (c >= 1) begin
                e = ref_calc(bp_a[0], bp_b[0], 1'b0, bp_sub[0]);
                checkOutput("stall_hold", {13'b0, out_valid, sum, cout, ovf}, {13'b0, 1'b1, e});
            end
        end
        checkOutput("bp_accepts", idx, 32'd2);
        checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);

        out_ready = 1'b1;
        applyStimulus(bp_a[idx], bp_b[idx], 1'b0, bp_sub[idx], 1'b1);
        run_cycle(acc, pop);
        checkOutput("push_pop_same_cycle", {30'b0, acc, pop}, 32'd3);
        if (acc) idx++;
        pops = pop ? 1 : 0;
        cycles = 0;
        while ((idx < 4 || exp_q.size() != 0) && cycles < 20) begin
            if (idx < 4) applyStimulus(bp_a[idx], bp_b[idx], 1'b0, bp_sub[idx], 1'b1);
            else         applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            run_cycle(acc, pop);
            if (acc) idx++;
            if (pop) pops++;
            cycles++;
        end
        checkOutput("bp_pop_count", pops, 32'd4);

        // Full-rate random stream: 100 beats should drain in 102 cycles
        exp_q.delete();
        applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1);
        idx = 0;
        pops = 0;
        cycles = 0;
        while ((idx < 100 || exp_q.size() != 0) && cycles < 300) begin
            run_cycle(acc, pop);
            cycles++;
            if (pop) pops++;
            if (acc) begin
                idx++;
                applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), idx < 100);
            end
        end
        checkOutput("full_rate_pops", pops, 32'd100);
        checkOutput("full_rate_cycles", cycles, 32'd102);
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs", {13'b0, out_valid, sum, cout, ovf}, 32'd0);
        checkOutput("midrun_reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("no_stale_after_reset", {31'b0, out_valid}, 32'd0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_latency1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_result", {13'b0, out_valid, sum, cout, ovf},
                    {13'b0, 1'b1, 16'h0100, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
